// File: rtl/multdiv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multdiv_sequencer
// Purpose  : 32-bit signed sequential multiplier / divider. One shift-add or
//            restoring-divide iteration per clock, 32 iterations, then a
//            one-cycle result strobe.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_sequencer (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        start;
  logic [4:0]  count;
  logic        is_mult;
  logic        neg;
  logic        div_zero;
  logic        div_ovf;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [31:0] opnd;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [63:0] acc;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] fin_result;
  logic        fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Single iteration datapaths for both operations share the acc register.
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  // When div_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign div_diff  = div_shift[31:0] - opnd;

  // Final sign correction and exception detection for the finished operation.
  always_comb begin
    prod_s     = neg ? (64'd0 - acc) : acc;
    quot_s     = neg ? (32'd0 - acc[31:0]) : acc[31:0];
    fin_result = 32'd0;
    fin_exc    = 1'b0;
    if (is_mult) begin
      fin_result = prod_s[31:0];
      fin_exc    = (prod_s[63:32] != {32{prod_s[31]}});
    end else if (div_zero) begin
      fin_result = 32'd0;
      fin_exc    = 1'b1;
    end else begin
      fin_result = quot_s;
      fin_exc    = div_ovf;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start restarts the sequence from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt = RUN;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      count          <= 5'd0;
      is_mult        <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      opnd           <= 32'd0;
      acc            <= 64'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        count    <= 5'd0;
        is_mult  <= ctrl_MULT;
        neg      <= data_operandA[31] ^ data_operandB[31];
        div_zero <= (data_operandB == 32'd0);
        div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        opnd     <= ctrl_MULT ? mag_a : mag_b;
        acc      <= {32'd0, (ctrl_MULT ? mag_b : mag_a)};
      end else if (state == RUN) begin
        count <= count + 5'd1;
        if (is_mult) begin
          acc <= {mul_sum, acc[31:1]};
        end else begin
          acc <= {(div_ge ? div_diff : div_shift[31:0]), acc[30:0], div_ge};
        end
      end else if (state == DONE) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
        data_resultRDY <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multdiv_sequencer
// Purpose  : Scoreboard bench for multdiv_sequencer with an arithmetic
//            reference model, directed corner cases and random operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          passed = 0;
  int          total  = 0;

  multdiv_sequencer dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Edge counter: value seen at a negedge equals the index of the last rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain signed 64-bit arithmetic.
  function automatic exp_t ref_op(input bit mult, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint p;
    logic [31:0] lo;
    e.cyc = 0;
    if (mult) begin
      p     = longint'($signed(x)) * longint'($signed(y));
      lo    = p[31:0];
      e.res = lo;
      e.exc = (p != longint'($signed(lo)));
    end else if (y == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      p     = longint'($signed(x)) / longint'($signed(y));
      e.res = p[31:0];
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every RDY pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", {31'd0, data_resultRDY}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("rdy_cycle", cyc, e.cyc);
      end
    end
  end

  // Call at a negedge. Drives a one-cycle start; a pending op is aborted.
  task automatic issue(input bit mult, input bit both, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = ref_op(mult, x, y);
    e.cyc = cyc + 1 + 33;
    if (sb.size() > 0) void'(sb.pop_back());
    ctrl_MULT     = mult;
    ctrl_DIV      = both | !mult;
    data_operandA = x;
    data_operandB = y;
    sb.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      check("timeout_pending", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    bit          m;
    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;

    // Directed corner cases.
    issue(1'b1, 1'b0, 32'd7, -32'sd6);                     wait_done();
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);       wait_done();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);               wait_done();
    issue(1'b0, 1'b0, -32'sd7, 32'd2);                     wait_done();
    issue(1'b0, 1'b0, 32'd5, 32'd0);                       wait_done();
    issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);       wait_done();
    issue(1'b0, 1'b0, 32'h8000_0000, 32'd1);               wait_done();
    // Both starts together: multiply wins.
    issue(1'b1, 1'b1, 32'd3, 32'd4);                       wait_done();

    // Abort: DIV 10/3 at S+10 replaces the running multiply.
    issue(1'b1, 1'b0, 32'd123, 32'd456);
    repeat (9) @(negedge clock);
    issue(1'b0, 1'b0, 32'd10, 32'd3);
    wait_done();

    // Reset mid-run, then a start on the first edge after release.
    issue(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (19) @(negedge clock);
    ctrl_reset_n = 1'b0;
    #1;
    check("midrun_reset_result", data_result, 32'd0);
    check("midrun_reset_exception", {31'd0, data_exception}, 32'd0);
    check("midrun_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    ctrl_reset_n = 1'b1;
    issue(1'b1, 1'b0, 32'd3, 32'd3);
    wait_done();

    // Randomized operations with biased operand classes.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = 32'($urandom_range(0, 200)) - 32'd100; y = 32'($urandom_range(0, 200)) - 32'd100; end
        2: begin x = $urandom; y = 32'($urandom_range(0, 20)) - 32'd10; end
        3: begin x = 32'h8000_0000; y = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
        default: begin x = $urandom >> $urandom_range(0, 31); y = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(m, 1'b0, x, y);
      wait_done();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: ctrl_reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: ctrl_MULT  input  1  start signed multiply, one-cycle pulse.
REQ-004 SHALL have port: ctrl_DIV  input  1  start signed divide, one-cycle pulse.
REQ-005 SHALL have port: data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-006 SHALL have port: data_operandB  input  32  multiplier or divisor, two's complement.
REQ-007 SHALL have port: data_result  output  32  product low word or quotient.
REQ-008 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag.
REQ-009 SHALL have port: data_resultRDY  output  1  result-valid strobe, one cycle wide.
REQ-010 SHALL have no parameters; width is fixed at 32 and iteration count at 32.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL use an internal 5-bit iteration counter that counts 0..31, cleared on every accepted start.
REQ-013 SHALL accept a start on any rising edge where ctrl_MULT or ctrl_DIV is 1, in any state, and capture both operands and the op type on that edge (edge S).
REQ-014 SHALL give ctrl_MULT priority when both starts are 1 on the same edge.
REQ-015 SHALL abort any operation in progress on a new start, discard its result, and begin the new operation from S.
REQ-016 SHALL perform one iteration per edge at S+1..S+32, then go RUN to DONE on edge S+32 when counter=31.
REQ-017 SHALL drive data_resultRDY=1 from edge S+33 to edge S+34 only, then return to IDLE with RDY=0.
REQ-018 SHALL hold data_result and data_exception stable from S+33 until the next accepted start.
REQ-019 SHALL leave data_result and data_exception unchanged from the previous operation during RUN.
REQ-020 SHALL compute the multiply by shift-add on operand magnitudes with final sign correction (sign = A[31] XOR B[31]).
REQ-021 SHALL set the multiply result to the low 32 bits of the exact 64-bit signed product.
REQ-022 SHALL set multiply data_exception=1 iff the upper 32 product bits differ from the sign-extension of result bit 31.
REQ-023 SHALL compute the divide by restoring division on magnitudes.
REQ-024 SHALL truncate the quotient toward zero, negate it when operand signs differ, and discard the remainder.
REQ-025 SHALL handle divisor 0 as: data_exception=1, data_result=0x00000000, same 33-edge latency.
REQ-026 SHALL handle 0x80000000 / 0xFFFFFFFF as: data_exception=1, data_result=0x80000000.
REQ-027 SHALL treat 0x80000000 magnitude as unsigned 2^31 internally, so its magnitude does not overflow.
REQ-028 SHALL have no outputs that depend combinationally on inputs.

Reset
REQ-029 SHALL, when ctrl_reset_n=0, immediately force: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, internal registers cleared.
REQ-030 SHALL, on reset mid-RUN, never assert data_resultRDY for the aborted operation.
REQ-031 SHALL accept a start on the first rising edge after ctrl_reset_n deasserts.

Verification
REQ-032 SHALL cover: MULT A=7, B=-6 -> RDY only in cycle S+33, result=0xFFFFFFD6, exception=0.
REQ-033 SHALL cover: MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; and MULT 0x80000000 x 1 -> result=0x80000000, exception=0.
REQ-034 SHALL cover: DIV A=-7, B=2 -> result=0xFFFFFFFD, exception=0; and DIV A=5, B=0 -> result=0, exception=1 at S+33.
REQ-035 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-036 SHALL cover: MULT start, then DIV 10/3 pulsed at S+10 -> no RDY at S+33, single RDY at S+43 with result=3.
REQ-037 SHALL cover: reset asserted at S+20 -> outputs zero immediately, no RDY; then MULT 3x3 right after release -> result=9 after 33 edges.
